sa_inst_issue_ctrl: RTL and testbench
=====================================

Name: sa_inst_issue_ctrl

Overview:
- Sequencer between the AXI4-Lite-loaded systolic-array instruction buffer and the systolic-array core.
- On a start command it fetches a programmed run of instruction words from the buffer RAM and issues them one at a time to the SA over a valid/ready handshake.
- Honours per-instruction wait-for-completion and HALT opcodes; reports busy/done/issue-count status back to the AXI register bank.

Parameters:
- ADDR_WIDTH, 8, instruction buffer address width (depth 2**ADDR_WIDTH).
- INST_WIDTH, 32, instruction word width; opcode = inst[INST_WIDTH-1 -: 4], wait flag = inst[INST_WIDTH-5].

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle start pulse from control register.
- abort  in  1  one-cycle abort pulse from control register.
- base_addr  in  ADDR_WIDTH  first instruction address, sampled on accepted start.
- inst_count  in  ADDR_WIDTH+1  number of words to issue, sampled on accepted start.
- ibuf_rd_en  out  1  buffer read enable.
- ibuf_rd_addr  out  ADDR_WIDTH  buffer read address.
- ibuf_rd_data  in  INST_WIDTH  buffer read data, valid the cycle after ibuf_rd_en.
- inst_valid  out  1  instruction valid to SA.
- inst_data  out  INST_WIDTH  instruction to SA.
- inst_ready  in  1  SA accepts instruction.
- sa_done  in  1  SA completion pulse.
- busy  out  1  high while not IDLE.
- done  out  1  sticky; set on normal completion, cleared on accepted start or reset.
- issued_cnt  out  ADDR_WIDTH+1  instructions handshaken in the current/last run.

Behaviour:
- Reset: state=IDLE; all outputs 0; internal pointer, remaining count and instruction register 0.
- Priority: reset > abort > start.
- States: IDLE, FETCH, DECODE, ISSUE, WAIT_DONE, FIN.
- IDLE:
  - start with inst_count!=0: latch ptr=base_addr, remain=inst_count; clear done and issued_cnt; go to FETCH.
  - start with inst_count==0: clear done and issued_cnt; go to FIN without any fetch.
- FETCH: ibuf_rd_en=1, ibuf_rd_addr=ptr for exactly one cycle; go to DECODE.
- DECODE: capture ibuf_rd_data into inst_reg.
  - opcode==4'hF (HALT): go to FIN; not forwarded; issued_cnt unchanged.
  - otherwise: go to ISSUE.
- ISSUE:
  - inst_valid=1, inst_data=inst_reg; both held stable until inst_valid&&inst_ready.
  - On handshake: issued_cnt+1, remain-1.
  - Wait flag set: go to WAIT_DONE.
  - Otherwise, remain was 1: go to FIN.
  - Otherwise: ptr+1 and go to FETCH.
- WAIT_DONE: hold until sa_done.
  - remain==0: go to FIN.
  - Otherwise: ptr+1 and go to FETCH.
  - sa_done in the handshake cycle itself does not count; only pulses seen in WAIT_DONE count.
- FIN: one cycle; set done=1; go to IDLE.
- ptr increments modulo 2**ADDR_WIDTH, so base_addr+count wraps past the top of the buffer.
- Latency: start accepted in cycle T → FETCH T+1, DECODE T+2, inst_valid first high T+3. Back-to-back non-wait issue with inst_ready=1 gives one instruction per 3 cycles.
- busy=1 in every state except IDLE, including FIN.
- start while busy is ignored; parameters are not re-sampled.
- abort in any non-IDLE state: IDLE next cycle; inst_valid deasserts immediately next cycle even mid-handshake; done stays 0; issued_cnt keeps its value. abort in IDLE has no effect.
- sa_done outside WAIT_DONE is ignored.
- inst_ready is ignored when inst_valid=0.
- Reset mid-run: same as the reset values above, no handshake completes.

Test Plan:
- Load buffer 0..3 = 0x00000001..0x00000004 (no wait flag); base_addr=0, inst_count=4, start; inst_ready=1 → four handshakes at T+3, T+6, T+9, T+12 with data 1..4 in order; done=1 at T+14; issued_cnt=4; busy=0 after FIN.
- Word at addr 2 = 0x08000002 (wait flag); sa_done pulse 5 cycles after its handshake → fetch of addr 3 starts the cycle after sa_done; also an sa_done pulse in the handshake cycle is ignored.
- base_addr=0xFE, inst_count=4 → reads addresses 0xFE, 0xFF, 0x00, 0x01; issued_cnt=4.
- Word at addr 1 = 0xF0000000, inst_count=4 → only addr 0 is issued; done=1; issued_cnt=1; addr 2 never read.
- inst_ready held low for 10 cycles → inst_valid and inst_data stable throughout; abort on cycle 5 → state IDLE, inst_valid=0, done=0, issued_cnt=0; a second start during the run has no effect.
- inst_count=0 start → no ibuf_rd_en; done=1 two cycles after start; reset asserted mid-ISSUE → all outputs 0 next cycle.

Source files
------------

// File: rtl/sa_inst_issue_ctrl.sv
// sa_inst_issue_ctrl: fetches a programmed run of instruction words from the
// systolic-array instruction buffer and issues them one at a time to the SA.
// Handles per-instruction wait-for-completion and HALT opcodes. Reports
// busy/done/issued-count status back to the register bank.
//
// Handshake: an instruction transfers on the clock edge where o_inst_valid and
// i_inst_ready are both high. Once o_inst_valid is raised, it and o_inst_data
// stay stable until that edge. The only exceptions are abort and reset, which
// drop o_inst_valid on the next edge with no transfer. i_inst_ready is
// ignored while o_inst_valid is low.
module sa_inst_issue_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int INST_WIDTH = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH:0]   i_inst_count,
    output logic                  o_ibuf_rd_en,
    output logic [ADDR_WIDTH-1:0] o_ibuf_rd_addr,
    input  logic [INST_WIDTH-1:0] i_ibuf_rd_data,
    output logic                  o_inst_valid,
    output logic [INST_WIDTH-1:0] o_inst_data,
    input  logic                  i_inst_ready,
    input  logic                  i_sa_done,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH:0]   o_issued_cnt,
    output logic [2:0]            o_state
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_FIN       = 3'd5
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO = '0;
    localparam logic [3:0]            OP_HALT = 4'hF;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_ptr;
    logic [ADDR_WIDTH:0]     r_remain;
    logic [INST_WIDTH-1:0]   r_inst_reg;
    logic                    r_rd_en;
    logic                    r_inst_valid;
    logic                    r_busy;
    logic                    r_done;
    logic [ADDR_WIDTH:0]     r_issued_cnt;

    logic                    w_wait_flag;
    logic                    w_is_halt;
    logic                    w_handshake;

    assign w_wait_flag = r_inst_reg[INST_WIDTH-5];
    assign w_is_halt   = (i_ibuf_rd_data[INST_WIDTH-1 -: 4] == OP_HALT);
    assign w_handshake = r_inst_valid && i_inst_ready;

    // Sequencer FSM: all status and interface outputs are registered here
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_remain     <= '0;
            r_inst_reg   <= '0;
            r_rd_en      <= 1'b0;
            r_inst_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_issued_cnt <= '0;
        end else if (i_abort && (r_state != ST_IDLE)) begin
            // Abort drops everything in flight; counters keep their values
            r_state      <= ST_IDLE;
            r_rd_en      <= 1'b0;
            r_inst_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_rd_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_done       <= 1'b0;
                        r_issued_cnt <= '0;
                        r_busy       <= 1'b1;
                        if (i_inst_count != CNT_ZERO) begin
                            r_ptr    <= i_base_addr;
                            r_remain <= i_inst_count;
                            r_rd_en  <= 1'b1;
                            r_state  <= ST_FETCH;
                        end else begin
                            r_state <= ST_FIN;
                        end
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    r_inst_reg <= i_ibuf_rd_data;
                    if (w_is_halt) begin
                        r_state <= ST_FIN;
                    end else begin
                        r_inst_valid <= 1'b1;
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_handshake) begin
                        r_inst_valid <= 1'b0;
                        r_issued_cnt <= r_issued_cnt + CNT_ONE;
                        r_remain     <= r_remain - CNT_ONE;
                        if (w_wait_flag) begin
                            r_state <= ST_WAIT_DONE;
                        end else if (r_remain == CNT_ONE) begin
                            r_state <= ST_FIN;
                        end else begin
                            r_ptr   <= r_ptr + PTR_ONE;
                            r_rd_en <= 1'b1;
                            r_state <= ST_FETCH;
                        end
                    end
                end
                ST_WAIT_DONE: begin
                    if (i_sa_done) begin
                        if (r_remain == CNT_ZERO) begin
                            r_state <= ST_FIN;
                        end else begin
                            r_ptr   <= r_ptr + PTR_ONE;
                            r_rd_en <= 1'b1;
                            r_state <= ST_FETCH;
                        end
                    end
                end
                ST_FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ibuf_rd_en   = r_rd_en;
    assign o_ibuf_rd_addr = r_ptr;
    assign o_inst_valid   = r_inst_valid;
    assign o_inst_data    = r_inst_reg;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_issued_cnt   = r_issued_cnt;
    assign o_state        = r_state;

endmodule

// File: tb/tb_sa_inst_issue_ctrl.sv
// Bench for sa_inst_issue_ctrl. A synchronous RAM model stands in for the
// instruction buffer. The run model predicts the read addresses and the
// issued words from the buffer contents, base address and count. A per-cycle
// monitor compares the DUT against that prediction. Directed tests pin cycle
// timing with hand-computed literals.
module tb_sa_inst_issue_ctrl;
    localparam int AW = 8;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_start = 1'b0;
    logic          i_abort = 1'b0;
    logic [AW-1:0] i_base_addr = '0;
    logic [AW:0]   i_inst_count = '0;
    logic          o_ibuf_rd_en;
    logic [AW-1:0] o_ibuf_rd_addr;
    logic [IW-1:0] i_ibuf_rd_data = '0;
    logic          o_inst_valid;
    logic [IW-1:0] o_inst_data;
    logic          i_inst_ready = 1'b0;
    logic          i_sa_done = 1'b0;
    logic          o_busy;
    logic          o_done;
    logic [AW:0]   o_issued_cnt;
    logic [2:0]    o_state;

    sa_inst_issue_ctrl #(.ADDR_WIDTH(AW), .INST_WIDTH(IW)) dut (
        .i_clock        (clk),
        .i_reset        (i_reset),
        .i_start        (i_start),
        .i_abort        (i_abort),
        .i_base_addr    (i_base_addr),
        .i_inst_count   (i_inst_count),
        .o_ibuf_rd_en   (o_ibuf_rd_en),
        .o_ibuf_rd_addr (o_ibuf_rd_addr),
        .i_ibuf_rd_data (i_ibuf_rd_data),
        .o_inst_valid   (o_inst_valid),
        .o_inst_data    (o_inst_data),
        .i_inst_ready   (i_inst_ready),
        .i_sa_done      (i_sa_done),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_issued_cnt   (o_issued_cnt),
        .o_state        (o_state)
    );

    // ---------------- clock / cycle counter / buffer RAM ----------------
    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    logic [IW-1:0] mem [256];
    always @(posedge clk) if (o_ibuf_rd_en) i_ibuf_rd_data <= mem[o_ibuf_rd_addr];

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_err = 0;

    logic [IW-1:0] exp_q[$];
    logic [AW-1:0] exp_rd_q[$];
    int            hs_cyc_q[$];
    int            rd_cyc_q[$];
    logic [AW-1:0] rd_addr_q[$];
    int            done_cyc = -1;

    bit            mon_en = 1'b0;
    bit            clr_pending = 1'b0;
    int            mon_cnt = 0;
    bit            p_stall = 1'b0;
    logic [IW-1:0] p_data = '0;
    bit            p_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s (cycle %0d)", name, cyc_n);
    endtask

    // ---------------- driver tasks ----------------
    task automatic goto(input int c);
        while (cyc_n < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic step();
        goto(cyc_n + 1);
    endtask

    // A run reads base+i (mod 256) for each word. It stops after a HALT word
    // is read, and issues every non-HALT word it reads.
    task automatic model_load(input logic [AW-1:0] base, input int count);
        logic [AW-1:0] a;
        for (int i = 0; i < count; i++) begin
            a = base + AW'(i);
            exp_rd_q.push_back(a);
            if (mem[a][IW-1 -: 4] == 4'hF) break;
            exp_q.push_back(mem[a]);
        end
    endtask

    task automatic flush();
        exp_q.delete();
        exp_rd_q.delete();
    endtask

    task automatic start_run(input logic [AW-1:0] base, input int count, output int t);
        model_load(base, count);
        hs_cyc_q.delete();
        rd_cyc_q.delete();
        rd_addr_q.delete();
        done_cyc = -1;
        i_base_addr = base;
        i_inst_count = (AW+1)'(count);
        i_start = 1'b1;
        clr_pending = 1'b1;
        t = cyc_n;
        step();
        i_start = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int k;
        k = 0;
        while (o_busy && k < limit) begin
            step();
            k++;
        end
        if (o_busy) fail("timeout_busy");
        step();
    endtask

    task automatic drained(input string tag);
        chk({tag, "_exp_q_left"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_exp_rd_left"}, 64'(exp_rd_q.size()), 64'd0);
    endtask

    // ---------------- scoreboard / compare process ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            chk("issued_cnt", 64'(o_issued_cnt), 64'(mon_cnt));
            if (p_stall) begin
                chk("hold_valid", 64'(o_inst_valid), 64'd1);
                chk("hold_data", 64'(o_inst_data), 64'(p_data));
            end
            if (!o_busy) chk("idle_no_valid", 64'(o_inst_valid), 64'd0);
            if (o_ibuf_rd_en) begin
                rd_cyc_q.push_back(cyc_n);
                rd_addr_q.push_back(o_ibuf_rd_addr);
                if (exp_rd_q.size() == 0) fail("unexpected_read");
                else chk("rd_addr", 64'(o_ibuf_rd_addr), 64'(exp_rd_q.pop_front()));
            end
            if (o_inst_valid && i_inst_ready && !i_reset && !i_abort) begin
                hs_cyc_q.push_back(cyc_n);
                if (exp_q.size() == 0) fail("unexpected_handshake");
                else chk("inst_data", 64'(o_inst_data), 64'(exp_q.pop_front()));
                mon_cnt++;
            end
            if (i_reset) mon_cnt = 0;
            else if (clr_pending && i_start) begin
                mon_cnt = 0;
                clr_pending = 1'b0;
            end
            if (o_done && !p_done) done_cyc = cyc_n;
            p_done = o_done;
            p_stall = o_inst_valid && !i_inst_ready && !i_abort && !i_reset;
            p_data = o_inst_data;
        end
    end

    // ---------------- directed tests ----------------
    int t;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 64'(o_state), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_valid", 64'(o_inst_valid), 64'd0);
        chk("rst_rd_en", 64'(o_ibuf_rd_en), 64'd0);
        chk("rst_cnt", 64'(o_issued_cnt), 64'd0);
        chk("rst_data", 64'(o_inst_data), 64'd0);
        i_reset = 1'b0;
        mon_en = 1'b1;
        step();

        // 1: four plain instructions, ready always high
        mem[0] = 32'h0000_0001; mem[1] = 32'h0000_0002;
        mem[2] = 32'h0000_0003; mem[3] = 32'h0000_0004;
        i_inst_ready = 1'b1;
        start_run(8'h00, 4, t);
        wait_idle(100);
        if (hs_cyc_q.size() == 4) begin
            for (int k = 0; k < 4; k++) chk($sformatf("t1_hs_cycle%0d", k), 64'(hs_cyc_q[k]), 64'(t + 3 + 3 * k));
        end else fail("t1_hs_count");
        chk("t1_done_cycle", 64'(done_cyc), 64'(t + 14));
        chk("t1_issued", 64'(o_issued_cnt), 64'd4);
        chk("t1_done", 64'(o_done), 64'd1);
        chk("t1_busy", 64'(o_busy), 64'd0);
        drained("t1");

        // 2: wait flag on word 2; sa_done in handshake cycle ignored
        mem[0] = 32'h0000_0010; mem[1] = 32'h0000_0011;
        mem[2] = 32'h0800_0002; mem[3] = 32'h0000_0013;
        start_run(8'h00, 4, t);
        goto(t + 9);  i_sa_done = 1'b1;
        goto(t + 10); i_sa_done = 1'b0;
        goto(t + 14); i_sa_done = 1'b1;
        goto(t + 15); i_sa_done = 1'b0;
        wait_idle(100);
        if (rd_cyc_q.size() == 4) chk("t2_fetch3_cycle", 64'(rd_cyc_q[3]), 64'(t + 15));
        else fail("t2_read_count");
        if (hs_cyc_q.size() == 4) chk("t2_hs3_cycle", 64'(hs_cyc_q[3]), 64'(t + 17));
        else fail("t2_hs_count");
        chk("t2_done_cycle", 64'(done_cyc), 64'(t + 19));
        chk("t2_issued", 64'(o_issued_cnt), 64'd4);
        drained("t2");

        // 3: address wrap past the top of the buffer
        mem[8'hFE] = 32'h0000_00A0; mem[8'hFF] = 32'h0000_00A1;
        mem[8'h00] = 32'h0000_00A2; mem[8'h01] = 32'h0000_00A3;
        start_run(8'hFE, 4, t);
        wait_idle(100);
        if (rd_addr_q.size() == 4) begin
            chk("t3_addr0", 64'(rd_addr_q[0]), 64'h0FE);
            chk("t3_addr1", 64'(rd_addr_q[1]), 64'h0FF);
            chk("t3_addr2", 64'(rd_addr_q[2]), 64'h000);
            chk("t3_addr3", 64'(rd_addr_q[3]), 64'h001);
        end else fail("t3_read_count");
        chk("t3_issued", 64'(o_issued_cnt), 64'd4);
        drained("t3");

        // 4: HALT at address 1
        mem[0] = 32'h0000_0055; mem[1] = 32'hF000_0000; mem[2] = 32'h0000_0077;
        start_run(8'h00, 4, t);
        wait_idle(100);
        chk("t4_issued", 64'(o_issued_cnt), 64'd1);
        chk("t4_done", 64'(o_done), 64'd1);
        chk("t4_reads", 64'(rd_cyc_q.size()), 64'd2);
        chk("t4_done_cycle", 64'(done_cyc), 64'(t + 7));
        drained("t4");

        // 5: ready held low, ignored restart, abort mid-stall
        mem[0] = 32'h1234_5678;
        i_inst_ready = 1'b0;
        start_run(8'h00, 4, t);
        goto(t + 4);
        i_start = 1'b1; i_base_addr = 8'h10; i_inst_count = 9'd1;
        goto(t + 5);
        i_start = 1'b0;
        goto(t + 8);
        chk("t5_valid_stall", 64'(o_inst_valid), 64'd1);
        chk("t5_data_stall", 64'(o_inst_data), 64'h1234_5678);
        i_abort = 1'b1;
        goto(t + 9);
        i_abort = 1'b0;
        chk("t5_state", 64'(o_state), 64'd0);
        chk("t5_valid", 64'(o_inst_valid), 64'd0);
        chk("t5_done", 64'(o_done), 64'd0);
        chk("t5_busy", 64'(o_busy), 64'd0);
        chk("t5_issued", 64'(o_issued_cnt), 64'd0);
        flush();
        goto(t + 13);
        i_inst_ready = 1'b1;
        goto(t + 16);
        i_inst_ready = 1'b0;
        chk("t5_issued_after", 64'(o_issued_cnt), 64'd0);
        chk("t5_reads", 64'(rd_cyc_q.size()), 64'd1);
        chk("t5_hs", 64'(hs_cyc_q.size()), 64'd0);

        // 6a: zero-length run
        start_run(8'h00, 0, t);
        chk("t6_busy_fin", 64'(o_busy), 64'd1);
        goto(t + 2);
        chk("t6_done", 64'(o_done), 64'd1);
        chk("t6_busy_idle", 64'(o_busy), 64'd0);
        goto(t + 4);
        chk("t6_reads", 64'(rd_cyc_q.size()), 64'd0);
        chk("t6_done_cycle", 64'(done_cyc), 64'(t + 2));

        // 6b: reset while presenting an instruction
        mem[0] = 32'h0000_00AB;
        start_run(8'h00, 2, t);
        goto(t + 4);
        chk("t6_valid_issue", 64'(o_inst_valid), 64'd1);
        i_reset = 1'b1;
        i_inst_ready = 1'b1;
        goto(t + 5);
        i_reset = 1'b0;
        i_inst_ready = 1'b0;
        chk("t6r_state", 64'(o_state), 64'd0);
        chk("t6r_valid", 64'(o_inst_valid), 64'd0);
        chk("t6r_data", 64'(o_inst_data), 64'd0);
        chk("t6r_busy", 64'(o_busy), 64'd0);
        chk("t6r_done", 64'(o_done), 64'd0);
        chk("t6r_issued", 64'(o_issued_cnt), 64'd0);
        chk("t6r_rd_en", 64'(o_ibuf_rd_en), 64'd0);
        chk("t6r_rd_addr", 64'(o_ibuf_rd_addr), 64'd0);
        flush();
        goto(t + 8);
        chk("t6r_hs", 64'(hs_cyc_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Hard stop in case a task loop is ever stuck
    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
